// File: rtl/exe_pipe.sv
// Registered execute stage with valid/ready handshake, flush and an optional
// iterative shift-add multiplier (built only when EXE_MUL_EN is defined).
module exe_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              exei_valid,
    output logic              exei_ready,
    input  logic [15:0]       exei_instr,
    input  logic [15:0]       exei_pc,
    input  logic [7:0]        exei_alu_opcode,
    input  logic [DATA_W-1:0] exei_op1,
    input  logic [DATA_W-1:0] exei_op2,
    input  logic [REG_AW-1:0] exei_wreg_addr,
    input  logic [DATA_W-1:0] exei_write_to_mem_data,
    input  logic [1:0]        exei_rwe,
    input  logic              exei_branch,
    output logic              exeo_valid,
    input  logic              exeo_ready,
    output logic [15:0]       exeo_instr,
    output logic [15:0]       exeo_pc,
    output logic [DATA_W-1:0] exeo_result,
    output logic [REG_AW-1:0] exeo_wreg_addr,
    output logic [DATA_W-1:0] exeo_write_to_mem_data,
    output logic [1:0]        exeo_rwe,
    output logic              exeo_branch,
    output logic              exeo_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FULL = 2'd1
`ifdef EXE_MUL_EN
        , S_MUL = 2'd2
`endif
    } state_t;

    state_t state_reg, state_next;

    logic              accept;
    logic              drain;
    logic              is_mul;
    logic              mul_active;
    logic              mul_done;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mul_product;
    logic [SH_W-1:0]   sh_amt;

    // exei_ready deliberately ignores exei_valid so no valid->ready loop exists
    assign exei_ready = !mul_active && (!exeo_valid || exeo_ready);
    assign accept     = exei_valid && exei_ready && !flush;
    assign drain      = exeo_valid && exeo_ready;
    assign sh_amt     = exei_op2[SH_W-1:0];

`ifdef EXE_MUL_EN
    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [SH_W-1:0]   cnt_reg;

    assign is_mul      = (exei_alu_opcode == 8'h09);
    assign mul_active  = (state_reg == S_MUL);
    assign mul_done    = mul_active && (cnt_reg == SH_W'(DATA_W - 1));
    assign mul_product = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // One multiplier bit per cycle; the final partial sum goes straight to the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (accept) begin
            mcand_reg  <= exei_op1;
            mplier_reg <= exei_op2;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (mul_active) begin
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            acc_reg    <= mul_product;
            cnt_reg    <= cnt_reg + SH_W'(1);
        end
    end
`else
    assign is_mul      = 1'b0;
    assign mul_active  = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_comb begin
        alu_result = '0;
        case (exei_alu_opcode)
            8'h00:   alu_result = '0;
            8'h01:   alu_result = exei_op1 + exei_op2;
            8'h02:   alu_result = exei_op1 - exei_op2;
            8'h03:   alu_result = exei_op1 & exei_op2;
            8'h04:   alu_result = {{(DATA_W-1){1'b0}}, (exei_op1 == exei_op2)};
            8'h05:   alu_result = exei_op1 << sh_amt;
            8'h06:   alu_result = exei_op1 | exei_op2;
            8'h07:   alu_result = exei_op1 >> sh_amt;
            8'h08:   alu_result = DATA_W'($signed(exei_op1) >>> sh_amt);
            default: alu_result = DATA_W'(8'hFE);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_FULL: begin
                    if (accept) begin
                        state_next = is_mul ? state_t'(2'd2) : S_FULL;
                    end else if (drain) begin
                        state_next = S_IDLE;
                    end
                end
`ifdef EXE_MUL_EN
                S_MUL: begin
                    if (mul_done) begin
                        state_next = S_FULL;
                    end
                end
`endif
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        exeo_valid = (state_reg == S_FULL);
        exeo_busy  = mul_active;
    end

    // Passthrough fields load on every accept; the result waits for the multiplier on MUL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exeo_instr             <= '0;
            exeo_pc                <= '0;
            exeo_result            <= '0;
            exeo_wreg_addr         <= '0;
            exeo_write_to_mem_data <= '0;
            exeo_rwe               <= '0;
            exeo_branch            <= 1'b0;
        end else if (accept) begin
            exeo_instr             <= exei_instr;
            exeo_pc                <= exei_pc;
            exeo_wreg_addr         <= exei_wreg_addr;
            exeo_write_to_mem_data <= exei_write_to_mem_data;
            exeo_rwe               <= exei_rwe;
            exeo_branch            <= exei_branch;
            if (!is_mul) begin
                exeo_result <= alu_result;
            end
        end else if (mul_done && !flush) begin
            exeo_result <= mul_product;
        end
    end

endmodule

// File: doc/exe_pipe.md
Name: exe_pipe

Overview:
- Parametrised, registered execute stage for the 16-bit pipelined CPU; successor to the purely combinational execute step.
- Sits between decode and memory stages. Adds a valid/ready handshake, an output register, flush, variable shifts, OR, and an optional iterative multiplier with multi-cycle stall.
- Carries instr, pc, write-register address, memory write data, rwe and branch alongside the ALU result.

Parameters:
- DATA_W, 16, operand/result width; must be a power of two and >= 8.
- REG_AW, 4, write-register address width.
- SH_W, $clog2(DATA_W), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- exei_valid  in  1  input holds an instruction.
- exei_ready  out  1  stage can accept this cycle.
- exei_instr  in  16  instruction word, passed through.
- exei_pc  in  16  pc, passed through.
- exei_alu_opcode  in  8  ALU operation.
- exei_op1, exei_op2  in  DATA_W  operands.
- exei_wreg_addr  in  REG_AW  destination register, passed through.
- exei_write_to_mem_data  in  DATA_W  store data, passed through.
- exei_rwe  in  2  memory read/write enable, passed through.
- exei_branch  in  1  branch flag, passed through.
- exeo_valid  out  1  output register holds a result.
- exeo_ready  in  1  downstream accepts this cycle.
- exeo_instr, exeo_pc, exeo_result, exeo_wreg_addr, exeo_write_to_mem_data, exeo_rwe, exeo_branch  out  as inputs  registered outputs.
- exeo_busy  out  1  multiply in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all exeo_* = 0, exeo_valid = 0, exeo_busy = 0, FSM in IDLE. exei_ready is combinational and evaluates to 1 after reset.
- Opcodes and results (all results DATA_W wide, wrap modulo 2^DATA_W):
  - 0x00 NOP = 0.
  - 0x01 ADD = op1+op2.
  - 0x02 SUB = op1-op2.
  - 0x03 AND = op1&op2.
  - 0x04 CMP = 1 if op1==op2, else 0.
  - 0x05 SHL = op1 << op2[SH_W-1:0].
  - 0x06 OR = op1|op2.
  - 0x07 SRL = op1 >> op2[SH_W-1:0], logical.
  - 0x08 SRA = op1 >>> op2[SH_W-1:0], arithmetic.
  - 0x09 MUL = low DATA_W bits of op1*op2, unsigned.
  - Any other opcode: result = 0x00FE, zero-extended.
- FSM states: IDLE (output empty), FULL (output valid), MUL (iterating).
- Handshake:
  - Transfer in occurs when exei_valid && exei_ready.
  - Transfer out occurs when exeo_valid && exeo_ready.
  - exei_ready = (state != MUL) && (!exeo_valid || exeo_ready).
- Single-cycle ops:
  - Latency 1: result and passthrough fields register on the accept edge; exeo_valid=1 next cycle.
  - Back-to-back accept with simultaneous drain gives full throughput, one op per cycle.
- MUL op:
  - Accept captures op1, op2 and all passthrough fields; if the output register was not being drained that edge, exeo_valid drops to 0.
  - Enters MUL with exeo_busy=1 and a counter=0, using shift-add of one multiplier bit per cycle.
  - After DATA_W cycles the product loads into exeo_result, exeo_valid=1, state FULL, exeo_busy=0.
  - Total latency is DATA_W+1 cycles from accept to exeo_valid.
- Output hold: while exeo_valid && !exeo_ready, every exeo_* output is stable.
- Drain with no new accept: exeo_valid=0 and state IDLE. Stale data may remain on the outputs while exeo_valid=0.
- Flush (synchronous, highest priority below reset):
  - Clears exeo_valid and exeo_busy, aborts MUL, returns to IDLE.
  - An input presented in the flush cycle is dropped.
- rst_n asserted mid-MUL: immediate return to reset values; no partial result is ever presented.
- exei_ready depends only on state, exeo_valid and exeo_ready. There is no combinational path from exei_valid to exei_ready.

Optional Feature:
- Macro: EXE_MUL_EN.
- Defined: MUL opcode 0x09, MUL state and exeo_busy behave as above.
- Undefined: no multiplier logic or MUL state is built. Opcode 0x09 is treated as an unknown opcode (result 0x00FE, latency 1), and exeo_busy is tied to 0.

Test Plan:
- Reset/ADD: assert rst_n=0 then release; op1=0xFFFF, op2=0x0002, ADD, exeo_ready=1 -> one cycle later exeo_valid=1, exeo_result=0x0001; passthrough pc/instr/wreg_addr/rwe/branch match the inputs.
- Backpressure: SUB op1=5, op2=7 accepted with exeo_ready=0 for 3 cycles -> exeo_result=0xFFFE held stable, exei_ready=0 during hold; next op accepted in the cycle exeo_ready=1.
- Shifts/CMP/unknown:
  - SHL 0x0001 by 15 -> 0x8000.
  - SRA 0x8000 by 4 -> 0xF800.
  - SRL 0x8000 by 4 -> 0x0800.
  - CMP 0x1234, 0x1234 -> 1.
  - Opcode 0x3F -> 0x00FE.
- MUL (EXE_MUL_EN): 0x0123*0x0045 -> exeo_busy=1 for 16 cycles, exei_ready=0 throughout, exeo_result=0x4E6F at cycle 17; without the macro, same stimulus -> 0x00FE after 1 cycle.
- Flush mid-MUL: flush at cycle 5 of MUL -> next cycle exeo_busy=0, exeo_valid=0, exei_ready=1; no result is ever presented.
- Async reset mid-MUL: rst_n low between clock edges -> outputs 0 immediately without waiting for a clock edge.
